rx_fifo_writer: RTL and testbench

- Producer end of the input FIFO that the sniffer controller drains.
- Accepts the MAC receive stream (Avalon-ST style: valid/ready, sop/eop, error, empty) and writes framed words into the input FIFO.
- Drives the controller's `ready`, `eop` and `error` inputs from frame boundaries.
- Enforces frame structure (orphan beats, missing eop, oversize) so the FIFO only ever holds well-delimited frames.

---
 rtl/rx_fifo_writer.sv | 222 ++++++++++++++++++++++
 tb/tb_rx_fifo_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo_writer.sv
// -----------------------------------------------------------------------------
// rx_fifo_writer
//
// Producer end of the sniffer controller's input FIFO. Takes the MAC receive
// stream (valid/ready, sop/eop, empty, error) and writes framed words into the
// FIFO. Only well-delimited frames reach the FIFO: orphan beats are
// discarded, a frame cut short by a new sop or by reaching MAX_WORDS is closed
// with an errored eop word, and the remainder of a broken frame is swallowed
// until its eop. Frame boundary pulses drive the controller's ready/eop/error
// inputs.
//
// Ports:
//   clk            system clock
//   n_rst          asynchronous active-low reset
//   rx_data        MAC beat data
//   rx_valid       MAC beat valid
//   rx_sop         first beat of frame
//   rx_eop         last beat of frame
//   rx_empty       unused bytes on the eop beat
//   rx_error       MAC error flag, qualified on the eop beat
//   rx_ready       backpressure to the MAC
//   wr_almost_full input FIFO has at most one free slot
//   wrreq          FIFO write request (registered)
//   wrdata         FIFO word {err, eop, sop, empty, data} (registered)
//   pkt_start      pulse: frame accepted into the FIFO
//   pkt_eop        pulse: terminating word written
//   pkt_error      pulse: frame terminated in error
//   drop_cnt       saturating count of discarded beats/frames
// -----------------------------------------------------------------------------
module rx_fifo_writer #(
    parameter int DATA_W    = 32,
    parameter int EMPTY_W   = 2,
    parameter int MAX_WORDS = 380
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_sop,
    input  logic                       rx_eop,
    input  logic [EMPTY_W-1:0]         rx_empty,
    input  logic                       rx_error,
    output logic                       rx_ready,
    input  logic                       wr_almost_full,
    output logic                       wrreq,
    output logic [DATA_W+EMPTY_W+2:0]  wrdata,
    output logic                       pkt_start,
    output logic                       pkt_eop,
    output logic                       pkt_error,
    output logic [15:0]                drop_cnt
);

    localparam int WORD_W = DATA_W + EMPTY_W + 3;
    localparam int CNT_W  = $clog2(MAX_WORDS + 1);
    // Count value held while the last permitted beat is being received.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_armed;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [15:0]        r_drop_cnt;
    logic               r_wrreq;
    logic [WORD_W-1:0]  r_wrdata;
    logic               r_pkt_start;
    logic               r_pkt_eop;
    logic               r_pkt_error;

    logic               w_rx_ready;
    logic               w_accept;

    // Build a FIFO word; the empty field only carries meaning on eop words.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [DATA_W-1:0]  data,
        input logic [EMPTY_W-1:0] empty,
        input logic               sop,
        input logic               eop,
        input logic               err
    );
        logic [EMPTY_W-1:0] empty_q;
        empty_q = eop ? empty : {EMPTY_W{1'b0}};
        return {err, eop, sop, empty_q, data};
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

    // Ready: DROP swallows beats regardless of FIFO level, elsewhere the
    // almost-full flag stalls the MAC one slot early because wrreq lags by a cycle.
    always_comb begin
        w_rx_ready = 1'b0;
        if (r_state == ST_DROP) begin
            w_rx_ready = r_armed;
        end else begin
            w_rx_ready = r_armed & ~wr_almost_full;
        end
    end

    assign w_accept = rx_valid & w_rx_ready;

    // Arming flop: keeps the MAC stalled for the first cycle after reset release.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Framing FSM with registered FIFO write and boundary pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= ST_IDLE;
            r_word_cnt  <= {CNT_W{1'b0}};
            r_drop_cnt  <= 16'd0;
            r_wrreq     <= 1'b0;
            r_wrdata    <= {WORD_W{1'b0}};
            r_pkt_start <= 1'b0;
            r_pkt_eop   <= 1'b0;
            r_pkt_error <= 1'b0;
        end else begin
            r_wrreq     <= 1'b0;
            r_pkt_start <= 1'b0;
            r_pkt_eop   <= 1'b0;
            r_pkt_error <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!rx_sop) begin
                            // Orphan beat outside any frame.
                            r_drop_cnt <= sat_inc16(r_drop_cnt);
                        end else begin
                            r_wrreq     <= 1'b1;
                            r_wrdata    <= pack_word(rx_data, rx_empty, 1'b1, rx_eop,
                                                     rx_eop & rx_error);
                            r_pkt_start <= 1'b1;
                            if (rx_eop) begin
                                r_pkt_eop   <= 1'b1;
                                r_pkt_error <= rx_error;
                                r_word_cnt  <= {CNT_W{1'b0}};
                                r_state     <= ST_IDLE;
                            end else begin
                                r_word_cnt  <= CNT_W'(1);
                                r_state     <= ST_RECEIVE;
                            end
                        end
                    end
                    ST_RECEIVE: begin
                        if (rx_sop) begin
                            // New sop inside an open frame: close the open frame in
                            // error. The word is written without its sop flag so the
                            // FIFO never sees a frame start that is not followed
                            // by a proper body.
                            r_wrreq     <= 1'b1;
                            r_wrdata    <= pack_word(rx_data, rx_empty, 1'b0, 1'b1, 1'b1);
                            r_pkt_eop   <= 1'b1;
                            r_pkt_error <= 1'b1;
                            r_drop_cnt  <= sat_inc16(r_drop_cnt);
                            r_word_cnt  <= {CNT_W{1'b0}};
                            if (rx_eop) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_DROP;
                            end
                        end else if (rx_eop) begin
                            r_wrreq     <= 1'b1;
                            r_wrdata    <= pack_word(rx_data, rx_empty, 1'b0, 1'b1, rx_error);
                            r_pkt_eop   <= 1'b1;
                            r_pkt_error <= rx_error;
                            r_word_cnt  <= {CNT_W{1'b0}};
                            r_state     <= ST_IDLE;
                        end else if (r_word_cnt == LAST_CNT) begin
                            // Oversize: the MAX_WORDS-th beat becomes an errored eop.
                            r_wrreq     <= 1'b1;
                            r_wrdata    <= pack_word(rx_data, {EMPTY_W{1'b0}}, 1'b0, 1'b1, 1'b1);
                            r_pkt_eop   <= 1'b1;
                            r_pkt_error <= 1'b1;
                            r_drop_cnt  <= sat_inc16(r_drop_cnt);
                            r_word_cnt  <= {CNT_W{1'b0}};
                            r_state     <= ST_DROP;
                        end else begin
                            r_wrreq    <= 1'b1;
                            r_wrdata   <= pack_word(rx_data, rx_empty, 1'b0, 1'b0, 1'b0);
                            r_word_cnt <= r_word_cnt + CNT_W'(1);
                        end
                    end
                    ST_DROP: begin
                        if (rx_eop) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_word_cnt <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    assign rx_ready  = w_rx_ready;
    assign wrreq     = r_wrreq;
    assign wrdata    = r_wrdata;
    assign pkt_start = r_pkt_start;
    assign pkt_eop   = r_pkt_eop;
    assign pkt_error = r_pkt_error;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_rx_fifo_writer.sv
// -----------------------------------------------------------------------------
// tb_rx_fifo_writer
//
// Directed bench for rx_fifo_writer with MAX_WORDS = 8. Each beat is driven
// until accepted and the registered outputs are checked one cycle later
// against hand-written expected FIFO words and pulses.
// -----------------------------------------------------------------------------
module tb_rx_fifo_writer;

    localparam int DW = 32;
    localparam int EW = 2;
    localparam int MW = 8;
    localparam int WW = DW + EW + 3;

    logic           clk = 1'b0;
    logic           n_rst;
    logic [DW-1:0]  rx_data;
    logic           rx_valid;
    logic           rx_sop;
    logic           rx_eop;
    logic [EW-1:0]  rx_empty;
    logic           rx_error;
    logic           rx_ready;
    logic           wr_almost_full;
    logic           wrreq;
    logic [WW-1:0]  wrdata;
    logic           pkt_start;
    logic           pkt_eop;
    logic           pkt_error;
    logic [15:0]    drop_cnt;

    int n_total = 0;
    int n_bad   = 0;

    rx_fifo_writer #(
        .DATA_W    (DW),
        .EMPTY_W   (EW),
        .MAX_WORDS (MW)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_sop         (rx_sop),
        .rx_eop         (rx_eop),
        .rx_empty       (rx_empty),
        .rx_error       (rx_error),
        .rx_ready       (rx_ready),
        .wr_almost_full (wr_almost_full),
        .wrreq          (wrreq),
        .wrdata         (wrdata),
        .pkt_start      (pkt_start),
        .pkt_eop        (pkt_eop),
        .pkt_error      (pkt_error),
        .drop_cnt       (drop_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Expected FIFO word {err, eop, sop, empty, data}.
    function automatic logic [WW-1:0] mk(input logic [DW-1:0] d, input logic [EW-1:0] e,
                                         input logic s, input logic eo, input logic er);
        return {er, eo, s, e, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one beat until accepted, then check outputs one cycle later.
    // exp_p = {pkt_start, pkt_eop, pkt_error}.
    task automatic send(input string tag, input logic [DW-1:0] d, input logic s,
                        input logic eo, input logic [EW-1:0] e, input logic er,
                        input logic exp_wr, input logic [WW-1:0] exp_wd,
                        input logic [2:0] exp_p);
        int waited;
        waited   = 0;
        rx_data  = d;
        rx_sop   = s;
        rx_eop   = eo;
        rx_empty = e;
        rx_error = er;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (!rx_ready) begin
            chk({tag, "_stall"}, 64'(rx_ready), 64'd1);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            rx_sop   = 1'b0;
            rx_eop   = 1'b0;
            rx_empty = '0;
            rx_error = 1'b0;
            chk({tag, "_wrreq"}, 64'(wrreq), 64'(exp_wr));
            if (exp_wr) begin
                chk({tag, "_wrdata"}, 64'(wrdata), 64'(exp_wd));
            end
            chk({tag, "_pulses"}, 64'({pkt_start, pkt_eop, pkt_error}), 64'(exp_p));
        end
    endtask

    // One idle cycle: nothing accepted, so nothing may be written.
    task automatic gap(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_idle_wrreq"}, 64'(wrreq), 64'd0);
        chk({tag, "_idle_pulses"}, 64'({pkt_start, pkt_eop, pkt_error}), 64'd0);
    endtask

    initial begin
        n_rst          = 1'b0;
        rx_data        = '0;
        rx_valid       = 1'b0;
        rx_sop         = 1'b0;
        rx_eop         = 1'b0;
        rx_empty       = '0;
        rx_error       = 1'b0;
        wr_almost_full = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wrreq", 64'(wrreq), 64'd0);
        chk("rst_wrdata", 64'(wrdata), 64'd0);
        chk("rst_pulses", 64'({pkt_start, pkt_eop, pkt_error}), 64'd0);
        chk("rst_ready", 64'(rx_ready), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        chk("arm_ready_lo", 64'(rx_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("arm_ready_hi", 64'(rx_ready), 64'd1);

        // 4-beat frame, empty = 2 on eop.
        send("f1b0", 32'h1111_0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h1111_0000, 2'd0, 1'b1, 1'b0, 1'b0), 3'b100);
        send("f1b1", 32'h1111_0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h1111_0001, 2'd0, 1'b0, 1'b0, 1'b0), 3'b000);
        send("f1b2", 32'h1111_0002, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h1111_0002, 2'd0, 1'b0, 1'b0, 1'b0), 3'b000);
        send("f1b3", 32'h1111_0003, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, mk(32'h1111_0003, 2'd2, 1'b0, 1'b1, 1'b0), 3'b010);
        gap("f1");
        chk("f1_drop", 64'(drop_cnt), 64'd0);

        // Same frame, errored eop.
        send("f2b0", 32'h2222_0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h2222_0000, 2'd0, 1'b1, 1'b0, 1'b0), 3'b100);
        send("f2b1", 32'h2222_0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h2222_0001, 2'd0, 1'b0, 1'b0, 1'b0), 3'b000);
        send("f2b2", 32'h2222_0002, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h2222_0002, 2'd0, 1'b0, 1'b0, 1'b0), 3'b000);
        send("f2b3", 32'h2222_0003, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, mk(32'h2222_0003, 2'd2, 1'b0, 1'b1, 1'b1), 3'b011);
        gap("f2");

        // Backpressure for 5 cycles mid-frame with valid held high.
        send("bp_b0", 32'h3333_0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h3333_0000, 2'd0, 1'b1, 1'b0, 1'b0), 3'b100);
        send("bp_b1", 32'h3333_0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h3333_0001, 2'd0, 1'b0, 1'b0, 1'b0), 3'b000);
        wr_almost_full = 1'b1;
        rx_data        = 32'h3333_0002;
        rx_valid       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", 64'(rx_ready), 64'd0);
            @(posedge clk);
            #1;
            chk("bp_wrreq", 64'(wrreq), 64'd0);
        end
        wr_almost_full = 1'b0;
        send("bp_b2", 32'h3333_0002, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h3333_0002, 2'd0, 1'b0, 1'b0, 1'b0), 3'b000);
        send("bp_b3", 32'h3333_0003, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, mk(32'h3333_0003, 2'd1, 1'b0, 1'b1, 1'b0), 3'b010);
        gap("bp");
        chk("bp_drop", 64'(drop_cnt), 64'd0);

        // Three orphan beats, then a valid 2-beat frame.
        send("orph0", 32'h4444_0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, '0, 3'b000);
        send("orph1", 32'h4444_0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, '0, 3'b000);
        send("orph2", 32'h4444_0002, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, '0, 3'b000);
        chk("orph_drop", 64'(drop_cnt), 64'd3);
        send("orf_b0", 32'h4444_1000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h4444_1000, 2'd0, 1'b1, 1'b0, 1'b0), 3'b100);
        send("orf_b1", 32'h4444_1001, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, mk(32'h4444_1001, 2'd3, 1'b0, 1'b1, 1'b0), 3'b010);
        chk("orf_drop", 64'(drop_cnt), 64'd3);

        // Oversize: 12-beat frame, beat 8 truncated, 9-12 swallowed. Almost-full
        // is raised during the discarded tail, which must not stall DROP.
        for (int i = 1; i <= 12; i++) begin
            if (i <= 7) begin
                send("ovs_body", 32'h5500_0000 + 32'(i), (i == 1), 1'b0, 2'd0, 1'b0, 1'b1,
                     mk(32'h5500_0000 + 32'(i), 2'd0, (i == 1), 1'b0, 1'b0),
                     (i == 1) ? 3'b100 : 3'b000);
            end else if (i == 8) begin
                send("ovs_trunc", 32'h5500_0008, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1,
                     mk(32'h5500_0008, 2'd0, 1'b0, 1'b1, 1'b1), 3'b011);
            end else begin
                wr_almost_full = 1'b1;
                send("ovs_tail", 32'h5500_0000 + 32'(i), 1'b0, (i == 12), 2'd0, 1'b0, 1'b0, '0, 3'b000);
            end
        end
        wr_almost_full = 1'b0;
        chk("ovs_drop", 64'(drop_cnt), 64'd4);
        send("ovs_next", 32'h5555_AAAA, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1,
             mk(32'h5555_AAAA, 2'd1, 1'b1, 1'b1, 1'b0), 3'b110);
        chk("ovs_next_drop", 64'(drop_cnt), 64'd4);

        // Missing eop: sop on beat 3 of an open frame.
        send("me_b0", 32'h6666_0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h6666_0000, 2'd0, 1'b1, 1'b0, 1'b0), 3'b100);
        send("me_b1", 32'h6666_0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h6666_0001, 2'd0, 1'b0, 1'b0, 1'b0), 3'b000);
        send("me_b2", 32'h6666_0002, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h6666_0002, 2'd0, 1'b0, 1'b0, 1'b0), 3'b000);
        send("me_b3", 32'h6666_0003, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h6666_0003, 2'd0, 1'b0, 1'b1, 1'b1), 3'b011);
        chk("me_drop", 64'(drop_cnt), 64'd5);
        send("me_drop4", 32'h6666_0004, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, '0, 3'b000);
        send("me_drop5", 32'h6666_0005, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, '0, 3'b000);
        send("me_next", 32'h6666_1000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1,
             mk(32'h6666_1000, 2'd3, 1'b1, 1'b1, 1'b1), 3'b111);
        chk("me_next_drop", 64'(drop_cnt), 64'd5);

        // Reset during beat 2 of a frame.
        send("rs_b0", 32'h7777_0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h7777_0000, 2'd0, 1'b1, 1'b0, 1'b0), 3'b100);
        send("rs_b1", 32'h7777_0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, mk(32'h7777_0001, 2'd0, 1'b0, 1'b0, 1'b0), 3'b000);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rs_wrreq", 64'(wrreq), 64'd0);
        chk("rs_wrdata", 64'(wrdata), 64'd0);
        chk("rs_pulses", 64'({pkt_start, pkt_eop, pkt_error}), 64'd0);
        chk("rs_ready", 64'(rx_ready), 64'd0);
        chk("rs_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        chk("rs_rel_ready_lo", 64'(rx_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rs_rel_ready_hi", 64'(rx_ready), 64'd1);
        send("rs_orph2", 32'h7777_0002, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, '0, 3'b000);
        send("rs_orph3", 32'h7777_0003, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, '0, 3'b000);
        chk("rs_orph_drop", 64'(drop_cnt), 64'd2);
        send("rs_next", 32'h7777_1000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1,
             mk(32'h7777_1000, 2'd0, 1'b1, 1'b1, 1'b0), 3'b110);
        gap("rs");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
